pix_timing_gen: RTL and testbench
=================================

// Module: pix_timing_gen
// PURPOSE
//  Video timing generator in the 40 MHz pixel-clock domain (50 MHz ref x4/5).
//  Consumes the pixel PLL clock and its LOCK output.
//  Qualifies LOCK, then produces registered hsync/vsync/de and pixel coordinates
//  for the 800x600@60 display and overlay path of the object tracker.
//  Drops to a quiet state whenever lock is lost.
// PARAMETERS
//  H_ACTIVE   800   visible pixels per line
//  H_FP       40    horizontal front porch (clocks)
//  H_SYNC     128   hsync width (clocks)
//  H_BP       88    horizontal back porch; H_TOTAL = 1056
//  V_ACTIVE   600   visible lines per frame
//  V_FP       1     vertical front porch (lines)
//  V_SYNC     4     vsync width (lines)
//  V_BP       23    vertical back porch; V_TOTAL = 628
//  HS_POL     1     hsync active level
//  VS_POL     1     vsync active level
//  LOCK_WAIT  1024  clocks of continuous synced lock required before RUN (>=1)
// PORTS
//  clk          in   1   pixel clock (PLL clkout)
//  rst_n        in   1   async active-low reset
//  pll_lock     in   1   PLL LOCK, asynchronous to clk
//  run          out  1   1 while timing is valid (state RUN)
//  hsync        out  1   horizontal sync, polarity HS_POL
//  vsync        out  1   vertical sync, polarity VS_POL
//  de           out  1   active-video enable
//  x            out  11  pixel column, 0..H_TOTAL-1
//  y            out  10  line number, 0..V_TOTAL-1
//  frame_start  out  1   one-clock pulse coincident with x=0, y=0 output
// BEHAVIOUR
//  Reset and lock qualification
//  - Reset (async assert, sync deassert internally via 2-flop): run=0, de=0, x=0, y=0,
//    frame_start=0; hsync=~HS_POL, vsync=~VS_POL.
//  - pll_lock passes through a 2-flop synchroniser (lock_s); 2-clock latency.
//  State machine
//  - IDLE: counters held at 0; all outputs at their inactive (reset) values.
//    -> WAIT when lock_s=1.
//  - WAIT: wait counter increments each clock while lock_s=1.
//    -> IDLE on lock_s=0, wait counter cleared.
//    -> RUN when wait counter == LOCK_WAIT-1.
//  - RUN: -> IDLE on lock_s=0. The IDLE outputs apply on the clock after lock_s falls;
//    a frame in progress is abandoned and never resumed mid-frame.
//  Counters (RUN only)
//  - h_cnt increments each clock and wraps H_TOTAL-1 -> 0.
//  - v_cnt increments on the h_cnt wrap and wraps V_TOTAL-1 -> 0 at the same edge.
//  - First RUN clock has (h_cnt, v_cnt) = (0, 0).
//  Registered outputs
//  - All outputs are registered from the (h_cnt, v_cnt) of the previous clock.
//    Latency is 1 clock, and all outputs are mutually aligned.
//  - de = run & (h < H_ACTIVE) & (v < V_ACTIVE).
//  - hsync is active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//  - vsync is active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
//    (whole lines, changes at h=0).
//  - frame_start = run & h==0 & v==0; one pulse per frame.
//  - x = h_cnt, y = v_cnt. Both outputs are 0 outside RUN.
//  Width rules
//  - H_TOTAL must be < 2048 and V_TOTAL must be < 1024; checked by elaboration-time assertion.
//  - All compares are unsigned.
// STRUCTURE
//  - Package pix_timing_pkg holds:
//    - 800x600@60 timing constants and derived H_TOTAL / V_TOTAL;
//    - X_W=11, Y_W=10;
//    - the state encoding typedef {IDLE, WAIT, RUN}.
//  - One sub-module, lock_qualifier, contains the synchroniser, the wait counter,
//    and the IDLE/WAIT/RUN FSM; its output is run_next.
//  - Counters and output registers sit in the top level.
// TESTING
//  1. Reset with pll_lock=1 held -> run rises exactly 2+LOCK_WAIT clocks after rst_n
//     release (+/-1 for sync). First output has x=0, y=0, de=1, frame_start=1.
//  2. Full frame at default params:
//     - count de=1 clocks -> 480000;
//     - hsync pulses per frame -> 628, each 128 clocks wide, starting at x=840;
//     - vsync -> 4 lines wide, starting at y=601;
//     - frame_start period -> 663168 clocks.
//  3. Wrap check: at x=1055, y=627 -> next output x=0, y=0, frame_start=1.
//     No x=1056 or y=628 is ever seen.
//  4. Lock glitch during WAIT (lock low for 3 clocks at count 500) -> wait restarts.
//     run rises LOCK_WAIT clocks after lock_s returns, not earlier.
//  5. Lock drop mid-frame (x=400, y=300):
//     - within 3 clocks run=0, de=0, syncs inactive, x=y=0;
//     - after relock, the next frame starts at (0,0) with frame_start.
//  6. Async reset asserted mid-frame -> outputs take reset values immediately, without a clock edge.
//     Small-parameter build (H 8/2/2/2, V 4/1/1/1) -> sync and de placement matches the formulas.

Source files
------------

// File: rtl/pix_timing_pkg.sv
// Shared 800x600@60 timing constants, raster counter widths and the
// lock-qualification state encoding used by pix_timing_gen.
package pix_timing_pkg;

  // Default horizontal timing (pixel clocks).
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Default vertical timing (lines).
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync polarities and lock qualification time.
  localparam logic DEF_HS_POL    = 1'b1;
  localparam logic DEF_VS_POL    = 1'b1;
  localparam int   DEF_LOCK_WAIT = 1024;

  // Raster coordinate widths.
  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/pix_timing_gen_lock_qualifier.sv
// Synchronises the PLL lock, requires LOCK_WAIT clocks of continuous lock,
// and reports through run_next whether the raster runs in the current clock.
module lock_qualifier
  import pix_timing_pkg::*;
#(
  parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic core_rst_n,
  input  logic pll_lock,
  output logic run_next
);

  localparam int              CNT_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       lock_sync_r;
  logic             lock_s;
  lock_state_e      state_r;
  lock_state_e      state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_nxt_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], pll_lock};
    end
  end

  assign lock_s = lock_sync_r[1];

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state logic; the IDLE clock that first sees lock counts as lock clock one,
  // and run_next rises in the clock that completes LOCK_WAIT clocks of lock.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    run_next       = 1'b0;
    case (state_r)
      IDLE: begin
        wait_cnt_nxt_s = CNT_ZERO;
        if (lock_s) begin
          if (LOCK_WAIT <= 1) begin
            state_nxt_s = RUN;
            run_next    = 1'b1;
          end else begin
            state_nxt_s    = WAIT;
            wait_cnt_nxt_s = CNT_ONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!lock_s) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = CNT_ZERO;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = CNT_ZERO;
          run_next       = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (lock_s) begin
          run_next = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/pix_timing_gen.sv
// Video timing generator: raster counters plus registered hsync/vsync/de,
// coordinates and frame_start, all forced quiet while the PLL is not qualified.
module pix_timing_gen
  import pix_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HS_POL    = DEF_HS_POL,
  parameter logic VS_POL    = DEF_VS_POL,
  parameter int   LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_lock,
  output logic           run,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEGIN  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEGIN  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);

  // Counters must fit their coordinate ports.
  if (H_TOTAL >= (2 ** X_W) || V_TOTAL >= (2 ** Y_W) || LOCK_WAIT < 1) begin : g_param_err
    $error("pix_timing_gen: H_TOTAL/V_TOTAL exceed coordinate width or LOCK_WAIT < 1");
  end

  logic [1:0]     rst_sync_r;
  logic           core_rst_n;
  logic           run_next;
  logic [X_W-1:0] h_r;
  logic [Y_W-1:0] v_r;
  logic           h_act_s;
  logic           v_act_s;
  logic           hs_on_s;
  logic           vs_on_s;
  logic           origin_s;

  // Reset synchroniser: asserts immediately, releases two clocks after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync_r[1];

  lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qualifier (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_rst_n (core_rst_n),
    .pll_lock   (pll_lock),
    .run_next   (run_next)
  );

  // Raster counters; outside RUN they are parked at the frame origin.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      h_r <= {X_W{1'b0}};
      v_r <= {Y_W{1'b0}};
    end else if (run_next) begin
      if (h_r == H_LAST) begin
        h_r <= {X_W{1'b0}};
        if (v_r == V_LAST) begin
          v_r <= {Y_W{1'b0}};
        end else begin
          v_r <= v_r + Y_W'(1);
        end
      end else begin
        h_r <= h_r + X_W'(1);
      end
    end else begin
      h_r <= {X_W{1'b0}};
      v_r <= {Y_W{1'b0}};
    end
  end

  // Decode the current raster position into the windows the outputs follow.
  always_comb begin
    h_act_s  = (h_r < H_ACT_END);
    v_act_s  = (v_r < V_ACT_END);
    hs_on_s  = (h_r >= HS_BEGIN) && (h_r < HS_END);
    vs_on_s  = (v_r >= VS_BEGIN) && (v_r < VS_END);
    origin_s = (h_r == {X_W{1'b0}}) && (v_r == {Y_W{1'b0}});
  end

  // Output registers, one clock behind the counters and mutually aligned.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      run         <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= {X_W{1'b0}};
      y           <= {Y_W{1'b0}};
      frame_start <= 1'b0;
    end else begin
      run         <= run_next;
      de          <= run_next & h_act_s & v_act_s;
      hsync       <= (run_next & hs_on_s) ? HS_POL : ~HS_POL;
      vsync       <= (run_next & vs_on_s) ? VS_POL : ~VS_POL;
      x           <= run_next ? h_r : {X_W{1'b0}};
      y           <= run_next ? v_r : {Y_W{1'b0}};
      frame_start <= run_next & origin_s;
    end
  end

endmodule

// File: tb/tb_pix_timing_gen.sv
// Directed bench for pix_timing_gen on a small raster (H 8/2/2/2, V 4/1/1/1).
module tb_pix_timing_gen;
  import pix_timing_pkg::*;

  localparam int   HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int   HT = 14, VT = 7, FRAME = 98;
  localparam int   LW = 16;
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b0;
  localparam int   NREC = 2 * FRAME + HT;
  localparam int   NVEC = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pll_lock = 1'b1;
  logic           run, hsync, vsync, de, frame_start;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   n;
    int   ex;
    int   ey;
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vec_t;

  vec_t        vecs[NVEC];
  logic [31:0] rec[NREC];

  pix_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (HPOL), .VS_POL (VPOL), .LOCK_WAIT (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .run         (run),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Packed view: {6'd0, run, x[10:0], y[9:0], de, hsync, vsync, frame_start}
  function automatic logic [31:0] outs();
    return {6'd0, run, x, y, de, hsync, vsync, frame_start};
  endfunction

  function automatic logic [31:0] exp_outs(input logic r, input int ex, input int ey,
                                           input logic d, input logic hs_a,
                                           input logic vs_a, input logic f);
    logic [10:0] xx;
    logic [9:0]  yy;
    xx = ex[10:0];
    yy = ey[9:0];
    return {6'd0, r, xx, yy, d, (hs_a ? HPOL : ~HPOL), (vs_a ? VPOL : ~VPOL), f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count rising clock edges from now until run is seen high.
  task automatic measure_run(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (run === 1'b1) begin
        n = i;
        break;
      end
    end
    check(name, n, 2 + LW);
  endtask

  task automatic wait_pos(input int wx, input int wy, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (x == wx[10:0] && y == wy[9:0]) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int de_cnt, hs_cyc, hs_pulses, hs_bad_start, vs_cyc, vs_first;
    int fs_cnt, fs_first, fs_second, max_x, max_y;
    int ex, ey;
    logic hs_a, vs_a, prev_hs;

    //              n    x  y  de    hs    vs    fs
    vecs[0]  = '{  0,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{  7,  7, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{  8,  8, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ 10, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{ 11, 11, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{ 12, 12, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ 14,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ 59,  3, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{ 70,  0, 5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{ 80, 10, 5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{ 84,  0, 6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ 97, 13, 6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{ 98,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{108, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{209, 13, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state and lock qualification from reset release.
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    repeat (3) tick();
    check("reset_state", outs(), exp_outs(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    measure_run("reset_to_run");
    check("first_output", outs(), exp_outs(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));

    // Record two frames plus a line of outputs.
    for (int n = 0; n < NREC; n++) begin
      if (n > 0) tick();
      rec[n] = outs();
    end

    // Table vectors.
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("vec_n%0d", vecs[i].n), rec[vecs[i].n],
            exp_outs(1'b1, vecs[i].ex, vecs[i].ey, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs));
    end

    // Every recorded cycle against the timing formulas.
    for (int n = 0; n < NREC; n++) begin
      ex = n % HT;
      ey = (n / HT) % VT;
      check($sformatf("model_n%0d", n), rec[n],
            exp_outs(1'b1, ex, ey, (ex < HA) && (ey < VA),
                     (ex >= HA + HF) && (ex < HA + HF + HS),
                     (ey >= VA + VF) && (ey < VA + VF + VS),
                     (ex == 0) && (ey == 0)));
    end

    // Frame-level statistics over the first frame.
    de_cnt = 0; hs_cyc = 0; hs_pulses = 0; hs_bad_start = 0; vs_cyc = 0; vs_first = -1;
    prev_hs = 1'b0;
    for (int n = 0; n < FRAME; n++) begin
      hs_a = (rec[n][2] == HPOL);
      vs_a = (rec[n][1] == VPOL);
      if (rec[n][3]) de_cnt++;
      if (hs_a) hs_cyc++;
      if (hs_a && !prev_hs) begin
        hs_pulses++;
        if (rec[n][24:14] != 11'(HA + HF)) hs_bad_start++;
      end
      if (vs_a) begin
        vs_cyc++;
        if (vs_first < 0) vs_first = n;
      end
      prev_hs = hs_a;
    end
    check("de_per_frame", de_cnt, HA * VA);
    check("hs_pulses", hs_pulses, VT);
    check("hs_total_width", hs_cyc, VT * HS);
    check("hs_bad_start", hs_bad_start, 0);
    check("vs_cycles", vs_cyc, VS * HT);
    check("vs_first", vs_first, (VA + VF) * HT);

    fs_cnt = 0; fs_first = -1; fs_second = -1; max_x = 0; max_y = 0;
    for (int n = 0; n < NREC; n++) begin
      if (rec[n][0]) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (int'(rec[n][24:14]) > max_x) max_x = int'(rec[n][24:14]);
      if (int'(rec[n][13:4]) > max_y) max_y = int'(rec[n][13:4]);
    end
    check("fs_count", fs_cnt, 3);
    check("fs_period", fs_second - fs_first, FRAME);
    check("max_x", max_x, HT - 1);
    check("max_y", max_y, VT - 1);

    // Lock drop mid-frame, then relock from the origin.
    wait_pos(5, 2, "reach_5_2");
    pll_lock = 1'b0;
    tick();
    tick();
    check("drop_edge2", outs(), exp_outs(1'b1, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    check("drop_idle", outs(), exp_outs(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (5) tick();
    check("drop_hold", outs(), exp_outs(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    pll_lock = 1'b1;
    measure_run("relock_to_run");
    check("relock_first", outs(), exp_outs(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));

    // Lock glitch during WAIT restarts qualification.
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (6) tick();
    check("glitch_idle", outs(), exp_outs(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    pll_lock = 1'b1;
    repeat (8) tick();
    check("glitch_pre_run", {31'd0, run}, 32'd0);
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    pll_lock = 1'b1;
    measure_run("glitch_restart");
    check("glitch_first", outs(), exp_outs(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));

    // Asynchronous reset mid-frame with both syncs active.
    wait_pos(10, 5, "reach_10_5");
    check("pre_reset", outs(), exp_outs(1'b1, 10, 5, 1'b0, 1'b1, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), exp_outs(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    measure_run("post_reset_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
